// File: rtl/lsu_bus_unit.sv
// Load/store unit: checks one core request, issues a single aligned bus beat
// with lane mask, and returns extended load data or an error code.
module lsu_bus_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [2:0]              req_func3,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [1:0]              resp_err,
  output logic                    bus_req_valid,
  input  logic                    bus_req_ready,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_wmask,
  input  logic                    bus_resp_valid,
  input  logic [DATA_WIDTH-1:0]   bus_resp_rdata,
  input  logic                    bus_resp_err,
  output logic [1:0]              dbg_state
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_BUS     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid side holds its payload stable until that edge.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              func3_q, func3_d;
  logic [OW-1:0]           off_q, off_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    bus_req_valid_q, bus_req_valid_d;
  logic                    bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
  logic [NB-1:0]           bus_wmask_q, bus_wmask_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]              resp_err_q, resp_err_d;

  logic [3:0]              size_b;
  logic [OW-1:0]           req_off;
  logic [NB-1:0]           lane_mask;
  logic                    req_illegal;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    resp_hit;
  logic                    to_hit;

  // Keep the low 8<<sz bits, then fill above with the sign bit or zeros.
  function automatic logic [DATA_WIDTH-1:0] extend_load(
    input logic [DATA_WIDTH-1:0] sh,
    input logic [1:0]            sz,
    input logic                  uns
  );
    logic [6:0]            nbits;
    logic [DATA_WIDTH-1:0] keep;
    logic                  s;
    nbits = 7'd8 << sz;
    keep  = ~({DATA_WIDTH{1'b1}} << nbits);
    s     = !uns && (|(sh & keep & ~(keep >> 1)));
    return (sh & keep) | ({DATA_WIDTH{s}} & ~keep);
  endfunction

  always_comb begin
    req_off     = req_addr[OW-1:0];
    size_b      = 4'd1 << req_func3[1:0];
    lane_mask   = NB'((16'd1 << size_b) - 16'd1) << req_off;
    req_illegal = (req_func3 == 3'b111) ||
                  (int'(size_b) > NB) ||
                  (req_wen && req_func3[2]) ||
                  ((req_off & OW'(size_b - 4'd1)) != '0);
  end

  assign load_data = extend_load(bus_resp_rdata >> {off_q, 3'b000}, func3_q[1:0], func3_q[2]);

  always_comb begin
    state_d         = state_q;
    func3_d         = func3_q;
    off_d           = off_q;
    cnt_d           = cnt_q;
    bus_req_valid_d = bus_req_valid_q;
    bus_we_d        = bus_we_q;
    bus_addr_d      = bus_addr_q;
    bus_wdata_d     = bus_wdata_q;
    bus_wmask_d     = bus_wmask_q;
    resp_rdata_d    = resp_rdata_q;
    resp_err_d      = resp_err_q;
    resp_hit        = 1'b0;
    to_hit          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          func3_d = req_func3;
          off_d   = req_off;
          if (req_illegal) begin
            state_d      = S_RESP;
            resp_err_d   = ERR_ILLEGAL;
            resp_rdata_d = '0;
          end else begin
            state_d         = S_ISSUE;
            cnt_d           = '0;
            bus_req_valid_d = 1'b1;
            bus_we_d        = req_wen;
            bus_addr_d      = {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            bus_wdata_d     = req_wdata << {req_off, 3'b000};
            bus_wmask_d     = req_wen ? lane_mask : '0;
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        cnt_d    = cnt_q + CW'(1);
        // A response accepted alongside the request counts as the WAIT response.
        resp_hit = bus_resp_valid && ((state_q == S_WAIT) || bus_req_ready);
        to_hit   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
        if (resp_hit) begin
          state_d         = S_RESP;
          bus_req_valid_d = 1'b0;
          resp_err_d      = bus_resp_err ? ERR_BUS : ERR_OK;
          resp_rdata_d    = (bus_resp_err || bus_we_q) ? '0 : load_data;
        end else if (to_hit) begin
          state_d         = S_RESP;
          bus_req_valid_d = 1'b0;
          resp_err_d      = ERR_TIMEOUT;
          resp_rdata_d    = '0;
        end else if ((state_q == S_ISSUE) && bus_req_ready) begin
          state_d         = S_WAIT;
          bus_req_valid_d = 1'b0;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_rdata_d = '0;
          resp_err_d   = ERR_OK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      func3_q         <= '0;
      off_q           <= '0;
      cnt_q           <= '0;
      bus_req_valid_q <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      bus_wmask_q     <= '0;
      resp_rdata_q    <= '0;
      resp_err_q      <= '0;
    end else begin
      state_q         <= state_d;
      func3_q         <= func3_d;
      off_q           <= off_d;
      cnt_q           <= cnt_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_wmask_q     <= bus_wmask_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wmask     = bus_wmask_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lsu_bus_unit.sv
// Bench for lsu_bus_unit: directed vector table, reset-mid-transaction sequence,
// and random transactions checked against a size/offset arithmetic model.
module tb_lsu_bus_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_resp_valid = 1'b0;
  logic [63:0] bus_resp_rdata = '0;
  logic        bus_resp_err = 1'b0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  lsu_bus_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
    .bus_resp_err(bus_resp_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          d_r;
    int          d_s;
    logic [63:0] bword;
    logic        berr;
    int          hold;
    logic [1:0]  e_err;
    logic [63:0] e_rdata;
    logic [7:0]  e_wmask;
    logic [63:0] e_wdata;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus model: accepts at cycle d_r, answers at cycle d_r+d_s; junk otherwise.
  task automatic drive_bus(input int c, input int d_r, input int d_s,
                           input logic [63:0] bword, input logic berr);
    bus_req_ready  = (c == d_r);
    bus_resp_valid = (c == d_r + d_s);
    bus_resp_rdata = (c == d_r + d_s) ? bword : {$urandom, $urandom};
    bus_resp_err   = (c == d_r + d_s) ? berr : 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge with the unit idle.
  task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input int d_r, input int d_s,
                         input logic [63:0] bword, input logic berr, input int hold,
                         input logic [1:0] e_err, input logic [63:0] e_rdata,
                         input logic [7:0] e_wmask, input logic [63:0] e_wdata);
    int  c;
    int  c_exp;
    bit  legal;
    legal = (e_err != 2'b01);
    c_exp = legal ? (((d_r + d_s) < (TO - 1) ? (d_r + d_s) : (TO - 1)) + 1) : 0;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_wen = wen; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    req_func3 = 3'($urandom_range(0, 7)); req_wen = 1'($urandom_range(0, 1));
    c = 0;
    while (!resp_valid && c < 40) begin
      chk("bus_req_valid", bus_req_valid, legal && (c <= d_r));
      chk("req_ready_busy", req_ready, 0);
      if (bus_req_valid) begin
        chk("bus_addr", bus_addr, {addr[63:3], 3'b000});
        chk("bus_we", bus_we, wen);
        chk("bus_wmask", bus_wmask, e_wmask);
        if (wen) chk("bus_wdata", bus_wdata, e_wdata);
      end
      drive_bus(c, d_r, d_s, bword, berr);
      @(posedge clk); @(negedge clk);
      c++;
    end
    chk("resp_latency", c, c_exp);
    chk("resp_valid_seen", resp_valid, 1);
    chk("bus_req_valid_in_resp", bus_req_valid, 0);
    chk("resp_err", resp_err, e_err);
    chk("resp_rdata", resp_rdata, e_rdata);
    for (int h = 0; h < hold; h++) begin
      drive_bus(c, d_r, d_s, bword, berr);
      @(posedge clk); @(negedge clk);
      c++;
      chk("resp_hold_valid", resp_valid, 1);
      chk("resp_hold_err", resp_err, e_err);
      chk("resp_hold_rdata", resp_rdata, e_rdata);
    end
    resp_ready = 1'b1;
    drive_bus(c, d_r, d_s, bword, berr);
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    chk("resp_valid_after", resp_valid, 0);
    chk("req_ready_after", req_ready, 1);
  endtask

  // Expected result straight from size/offset arithmetic.
  task automatic model(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] bword, input logic berr,
                       input int d_r, input int d_s,
                       output logic [1:0] err, output logic [63:0] rdata,
                       output logic [7:0] wmask, output logic [63:0] bwdata);
    int          size;
    int          off;
    int          m;
    logic [63:0] v;
    logic [63:0] keep;
    size   = 1 << f3[1:0];
    off    = int'(addr % 8);
    m      = ((1 << size) - 1) << off;
    wmask  = wen ? m[7:0] : 8'h00;
    bwdata = wdata << (8 * off);
    rdata  = '0;
    if (f3 == 3'b111 || (wen && f3[2]) || (off % size) != 0) err = 2'b01;
    else if (d_r + d_s >= TO) err = 2'b11;
    else if (berr) err = 2'b10;
    else begin
      err = 2'b00;
      if (!wen) begin
        v = bword >> (8 * off);
        if (size < 8) begin
          keep = (64'd1 << (8 * size)) - 64'd1;
          v = v & keep;
          if (!f3[2] && v[8 * size - 1]) v = v | ~keep;
        end
        rdata = v;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [1:0]  e_err;
    logic [63:0] e_rdata;
    logic [7:0]  e_wmask;
    logic [63:0] e_wdata;
    logic        wen, berr;
    logic [2:0]  f3;
    logic [63:0] addr, wdata, bword;
    int          d_r, d_s, hold;

    //         wen   f3      addr                   wdata                  d_r d_s bword                  berr hold err    rdata                  wmask  wdata
    vecs[0]  = '{1'b0, 3'b000, 64'h0000_0000_8000_0003, 64'h0,                 0, 1, 64'h0011_2233_4455_6677, 1'b0, 0, 2'b00, 64'h0000_0000_0000_0044, 8'h00, 64'h0};
    vecs[1]  = '{1'b0, 3'b101, 64'h0000_0000_8000_0006, 64'h0,                 0, 1, 64'h8123_0000_0000_0000, 1'b0, 1, 2'b00, 64'h0000_0000_0000_8123, 8'h00, 64'h0};
    vecs[2]  = '{1'b0, 3'b001, 64'h0000_0000_8000_0006, 64'h0,                 1, 1, 64'h8123_0000_0000_0000, 1'b0, 0, 2'b00, 64'hFFFF_FFFF_FFFF_8123, 8'h00, 64'h0};
    vecs[3]  = '{1'b1, 3'b010, 64'h0000_0000_8000_0004, 64'h0000_0000_DEAD_BEEF, 1, 2, 64'h0000_0000_0000_1234, 1'b0, 0, 2'b00, 64'h0, 8'hF0, 64'hDEAD_BEEF_0000_0000};
    vecs[4]  = '{1'b1, 3'b011, 64'h0000_0000_8000_0000, 64'h0123_4567_89AB_CDEF, 0, 1, 64'h0000_0000_0000_5555, 1'b0, 0, 2'b00, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF};
    vecs[5]  = '{1'b0, 3'b011, 64'h0000_0000_8000_0004, 64'h0,                 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 2'b01, 64'h0, 8'h00, 64'h0};
    vecs[6]  = '{1'b0, 3'b111, 64'h0000_0000_8000_0000, 64'h0,                 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 2'b01, 64'h0, 8'h00, 64'h0};
    vecs[7]  = '{1'b0, 3'b010, 64'h0000_0000_8000_0008, 64'h0,                 3, 0, 64'h0000_0000_0000_FFFF, 1'b1, 0, 2'b10, 64'h0, 8'h00, 64'h0};
    vecs[8]  = '{1'b0, 3'b010, 64'h0000_0000_8000_0010, 64'h0,                 0, 6, 64'h0000_0000_1111_2222, 1'b0, 5, 2'b11, 64'h0, 8'h00, 64'h0};
    vecs[9]  = '{1'b0, 3'b011, 64'h0000_0000_8000_0018, 64'h0,                 9, 0, 64'h0000_0000_3333_4444, 1'b0, 0, 2'b11, 64'h0, 8'h00, 64'h0};
    vecs[10] = '{1'b1, 3'b000, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB, 0, 1, 64'h0,                 1'b0, 0, 2'b00, 64'h0, 8'h20, 64'h0000_AB00_0000_0000};
    vecs[11] = '{1'b0, 3'b010, 64'h0000_0000_8000_0004, 64'h0,                 2, 1, 64'h89AB_CDEF_0000_0000, 1'b0, 0, 2'b00, 64'hFFFF_FFFF_89AB_CDEF, 8'h00, 64'h0};
    vecs[12] = '{1'b0, 3'b110, 64'h0000_0000_8000_0004, 64'h0,                 0, 2, 64'h89AB_CDEF_0000_0000, 1'b0, 0, 2'b00, 64'h0000_0000_89AB_CDEF, 8'h00, 64'h0};
    vecs[13] = '{1'b1, 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0011, 0, 1, 64'h0,                 1'b0, 0, 2'b01, 64'h0, 8'h00, 64'h0};

    // Reset values while rst is held.
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_bus_req_valid", bus_req_valid, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_wmask", bus_wmask, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i].wen, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].d_r, vecs[i].d_s,
              vecs[i].bword, vecs[i].berr, vecs[i].hold, vecs[i].e_err, vecs[i].e_rdata,
              vecs[i].e_wmask, vecs[i].e_wdata);
    end

    // Asynchronous reset while waiting on the bus: everything clears before the next edge.
    req_valid = 1'b1; req_wen = 1'b1; req_func3 = 3'b000;
    req_addr = 64'h0000_0000_8000_0001; req_wdata = 64'h5A;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; bus_req_ready = 1'b1;
    chk("pre_rst_wmask", bus_wmask, 8'h02);
    @(posedge clk); @(negedge clk);
    bus_req_ready = 1'b0;
    chk("pre_rst_wait_valid", bus_req_valid, 0);
    chk("pre_rst_busy", req_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_bus_addr", bus_addr, 0);
    chk("arst_bus_we", bus_we, 0);
    chk("arst_bus_wdata", bus_wdata, 0);
    chk("arst_bus_wmask", bus_wmask, 0);
    @(negedge clk);
    rst = 1'b0;
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF; bus_resp_err = 1'b0;
    @(posedge clk); @(negedge clk);
    bus_resp_valid = 1'b0;
    chk("idle_ignores_bus_resp", resp_valid, 0);
    chk("idle_after_arst", req_ready, 1);

    // Random transactions against the arithmetic model.
    for (int n = 0; n < 150; n++) begin
      wen   = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 255))};
      wdata = {$urandom, $urandom};
      bword = {$urandom, $urandom};
      berr  = ($urandom_range(0, 7) == 0);
      d_r   = $urandom_range(0, 5);
      d_s   = $urandom_range(0, 4);
      hold  = $urandom_range(0, 2);
      model(wen, f3, addr, wdata, bword, berr, d_r, d_s, e_err, e_rdata, e_wmask, e_wdata);
      run_txn(wen, f3, addr, wdata, d_r, d_s, bword, berr, hold, e_err, e_rdata, e_wmask, e_wdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
